// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave front end of the SPI-to-RAM subsystem.
//   state_t     : receive/transmit FSM states
//   CMD_*       : two-bit command codes carried in rx_data[9:8]
//   FRAME_BITS  : bits per MOSI frame for the default 8-bit data width
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Bundles the serial pins and the RAM-side command/read-data handshake.
//   MOSI, SS_n        : serial data in, active-low slave select
//   MISO              : serial read data out
//   rx_data, rx_valid : received {cmd, payload} word and its one-cycle strobe
//   tx_data, tx_valid : RAM read data and its one-cycle strobe
// Modports: slave (the SPI slave block), master (the SPI master plus RAM side).
// -----------------------------------------------------------------------------
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  MOSI;
    logic                  SS_n;
    logic                  MISO;
    logic [DATA_WIDTH+1:0] rx_data;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;

    modport slave (
        input  MOSI, SS_n, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );

    modport master (
        output MOSI, SS_n, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

endinterface

// File: rtl/spi_tx_shifter.sv
// -----------------------------------------------------------------------------
// spi_tx_shifter
// Parallel-load, MSB-first serialiser for RAM read data.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture data and drive its MSB on serial_out at this edge
//   shift      : advance one bit per edge while bits remain
//   abort      : drop remaining bits, serial_out to 0 at this edge
//   data       : parallel word to send
//   serial_out : registered serial output, 0 whenever nothing is being sent
//   busy       : bits still waiting to be shifted out
// -----------------------------------------------------------------------------
module spi_tx_shifter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             abort,
    input  logic [WIDTH-1:0] data,
    output logic             serial_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    remaining;

    // The MSB goes straight to serial_out on load, so the shift register
    // only holds the bits that still have to follow it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            remaining  <= '0;
            serial_out <= 1'b0;
        end else if (abort) begin
            shreg      <= '0;
            remaining  <= '0;
            serial_out <= 1'b0;
        end else if (load) begin
            serial_out <= data[WIDTH-1];
            shreg      <= {data[WIDTH-2:0], 1'b0};
            remaining  <= CW'(WIDTH - 1);
        end else if (shift && remaining != '0) begin
            serial_out <= shreg[WIDTH-1];
            shreg      <= {shreg[WIDTH-2:0], 1'b0};
            remaining  <= remaining - CW'(1);
        end else if (remaining == '0) begin
            serial_out <= 1'b0;
        end
    end

    assign busy = (remaining != '0);

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Deserialises MOSI frames into {cmd, payload} words for the RAM and
// serialises RAM read data back out on MISO. A frame starts when SS_n goes
// low; the first sampled bit picks write or read, and a remembered
// "read address loaded" flag picks between the read-address and read-data
// paths.
//   clk : system clock, also the SPI clock
//   rst : asynchronous active-high reset
//   bus : spi_slave_if.slave (MOSI, SS_n, MISO, rx_data, rx_valid,
//         tx_data, tx_valid)
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    localparam int FW = DATA_WIDTH + 2;
    localparam int CW = $clog2(FW + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(FW - 1);
    localparam logic [CW-1:0] FRAME_DONE = CW'(FW);

    state_t          state;
    logic            rd_addr_seen;
    logic [CW-1:0]   bit_cnt;
    logic [FW-2:0]   rx_shift;
    logic [FW-1:0]   rx_data_q;
    logic            rx_valid_q;
    logic            tx_done;

    logic            frame_done;
    logic            tx_load;
    logic            tx_abort;
    logic            tx_busy;
    logic            miso;

    assign frame_done = (bit_cnt == FRAME_DONE);

    // Only one transmission per read-data frame, and only after the whole
    // command word has arrived; tx_valid at any other time is ignored.
    assign tx_load  = (state == READ_DATA) && !bus.SS_n && frame_done &&
                      !tx_done && !tx_busy && bus.tx_valid;
    assign tx_abort = bus.SS_n || (state != READ_DATA);

    // Main FSM. SS_n high always wins and discards any partial frame.
    // bit_cnt counts received bits; once it reaches the frame width the
    // remaining MOSI bits are ignored until SS_n rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd_addr_seen <= 1'b0;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (bus.SS_n) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_done  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= CHK_CMD;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_done  <= 1'b0;
                    end
                    CHK_CMD: begin
                        rx_shift <= {rx_shift[FW-3:0], bus.MOSI};
                        bit_cnt  <= CW'(1);
                        if (!bus.MOSI) begin
                            state <= WRITE;
                        end else if (rd_addr_seen) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!frame_done) begin
                            rx_shift <= {rx_shift[FW-3:0], bus.MOSI};
                            bit_cnt  <= bit_cnt + CW'(1);
                            if (bit_cnt == LAST_BIT) begin
                                rx_data_q  <= {rx_shift, bus.MOSI};
                                rx_valid_q <= 1'b1;
                                if (state == READ_ADD) begin
                                    rd_addr_seen <= 1'b1;
                                end else if (state == READ_DATA) begin
                                    rd_addr_seen <= 1'b0;
                                end
                            end
                        end
                        if (tx_load) begin
                            tx_done <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    spi_tx_shifter #(
        .WIDTH (DATA_WIDTH)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .load       (tx_load),
        .shift      (state == READ_DATA),
        .abort      (tx_abort),
        .data       (bus.tx_data),
        .serial_out (miso),
        .busy       (tx_busy)
    );

    assign bus.MISO     = miso;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule
